// File: rtl/gdo_pkg.sv
// Shared arithmetic helpers and types for the general_data_operator datapath.
// gdo_add_sat clamps to a signed w-bit range and reports whether it clamped.
package gdo;

   localparam int GDO_DATA_W = 8;

   typedef enum logic [1:0] {ACCUM, DRAIN, OUTPUT} gdo_state_e;

   typedef struct packed {
      logic signed [63:0] sum;
      logic               ovf;
   } gdo_sat_t;

   function automatic logic signed [63:0] gdo_mult(input logic signed [31:0] a,
                                                    input logic signed [31:0] b);
      return 64'(a) * 64'(b);
   endfunction

   function automatic logic signed [63:0] gdo_add(input logic signed [63:0] a,
                                                   input logic signed [63:0] b);
      return a + b;
   endfunction

   // One extra bit of headroom so the raw sum of two 64-bit values never wraps.
   function automatic gdo_sat_t gdo_add_sat(input logic signed [63:0] a,
                                            input logic signed [63:0] b,
                                            input int                 w);
      logic signed [64:0] s, mx, mn;
      gdo_sat_t           r;
      s     = 65'(a) + 65'(b);
      mx    = (65'sd1 <<< (w - 1)) - 65'sd1;
      mn    = -mx - 65'sd1;
      r.sum = s[63:0];
      r.ovf = 1'b0;
      if (s > mx) begin
         r.sum = mx[63:0];
         r.ovf = 1'b1;
      end else if (s < mn) begin
         r.sum = mn[63:0];
         r.ovf = 1'b1;
      end
      return r;
   endfunction

endpackage

// File: rtl/gdo_mac_stream_sat_acc.sv
// Stage-2 saturating accumulator: adds a sign-extended product when enabled,
// keeps a sticky saturation flag, and clears both on clr_i.
module gdo_sat_acc
   import gdo::*;
#(
   parameter int ACC_W = 24,
   parameter int P_W   = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    clr_i,
   input  logic                    en_i,
   input  logic signed [P_W-1:0]   p_i,
   output logic signed [ACC_W-1:0] acc_o,
   output logic                    sat_o
);

   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic                    sat_q, sat_d;
   gdo_sat_t                add_r;
   logic                    unused_hi;

   always_comb add_r = gdo_add_sat(64'(acc_q), 64'(p_i), ACC_W);
   assign unused_hi = ^add_r.sum[63:ACC_W];

   always_comb begin
      acc_d = acc_q;
      sat_d = sat_q;
      if (clr_i) begin
         acc_d = '0;
         sat_d = 1'b0;
      end else if (en_i) begin
         acc_d = add_r.sum[ACC_W-1:0];
         sat_d = sat_q | add_r.ovf;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
         sat_q <= 1'b0;
      end else begin
         acc_q <= acc_d;
         sat_q <= sat_d;
      end
   end

   assign acc_o = acc_q;
   assign sat_o = sat_q;

endmodule

// File: rtl/gdo_mac_stream.sv
// Streaming signed dot-product stage: multiply register, saturating accumulate,
// one result per vector ended by in_last or by reaching MAX_LEN beats.
module gdo_mac_stream
   import gdo::*;
#(
   parameter  int DATA_W  = GDO_DATA_W,
   parameter  int ACC_W   = 24,
   parameter  int MAX_LEN = 256,
   localparam int CNT_W   = $clog2(MAX_LEN + 1)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [DATA_W-1:0] in_a,
   input  logic signed [DATA_W-1:0] in_b,
   input  logic                     in_last,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic signed [ACC_W-1:0]  out_data,
   output logic [CNT_W-1:0]         out_count,
   output logic                     out_sat,
   output logic                     out_trunc
);

   localparam int P_W = 2 * DATA_W;

   gdo_state_e            state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  trunc_q, trunc_d;
   logic signed [P_W-1:0] p_q;
   logic                  pv_q;
   logic signed [63:0]    prod_w;
   logic                  unused_prod;
   logic                  accept, out_hs;

   assign prod_w      = gdo_mult(32'(in_a), 32'(in_b));
   assign unused_prod = ^prod_w[63:P_W];

   assign in_ready  = (state_q == ACCUM);
   assign out_valid = (state_q == OUTPUT);
   assign accept    = in_valid & in_ready;
   assign out_hs    = out_valid & out_ready;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      trunc_d = trunc_q;
      case (state_q)
         ACCUM: begin
            if (accept) begin
               cnt_d = cnt_q + CNT_W'(1);
               // Reaching MAX_LEN ends the vector even without in_last.
               if (in_last || cnt_q == CNT_W'(MAX_LEN - 1)) begin
                  state_d = DRAIN;
                  trunc_d = ~in_last;
               end
            end
         end
         DRAIN:   state_d = OUTPUT;
         OUTPUT: begin
            if (out_ready) begin
               state_d = ACCUM;
               cnt_d   = '0;
               trunc_d = 1'b0;
            end
         end
         default: state_d = ACCUM;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ACCUM;
         cnt_q   <= '0;
         trunc_q <= 1'b0;
         p_q     <= '0;
         pv_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         trunc_q <= trunc_d;
         pv_q    <= accept;
         if (accept) p_q <= prod_w[P_W-1:0];
      end
   end

   gdo_sat_acc #(
      .ACC_W (ACC_W),
      .P_W   (P_W)
   ) u_acc (
      .clk   (clk),
      .rst_n (rst_n),
      .clr_i (out_hs),
      .en_i  (pv_q),
      .p_i   (p_q),
      .acc_o (out_data),
      .sat_o (out_sat)
   );

   assign out_count = cnt_q;
   assign out_trunc = trunc_q;

endmodule

// File: tb/tb_gdo_mac_stream.sv
// Directed bench for gdo_mac_stream with a 17-bit accumulator and MAX_LEN=8.
module tb_gdo_mac_stream;

   localparam int DW = 8;
   localparam int AW = 17;
   localparam int ML = 8;
   localparam int CW = $clog2(ML + 1);

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic                 in_valid = 1'b0;
   logic                 in_last = 1'b0;
   logic                 out_ready = 1'b0;
   logic signed [DW-1:0] in_a = '0;
   logic signed [DW-1:0] in_b = '0;
   logic                 in_ready, out_valid, out_sat, out_trunc;
   logic signed [AW-1:0] out_data;
   logic [CW-1:0]        out_count;

   int pass_cnt = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   gdo_mac_stream #(.DATA_W(DW), .ACC_W(AW), .MAX_LEN(ML)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_count (out_count),
      .out_sat   (out_sat),
      .out_trunc (out_trunc)
   );

   typedef struct {
      int first;
      int n;
      int exp_data;
      int exp_cnt;
      bit exp_sat;
      bit exp_trunc;
   } vec_t;

   byte qa[$];
   byte qb[$];

   task automatic chk(input string name, input longint act, input longint exp);
      total_cnt++;
      if (act == exp) pass_cnt++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic add_beats(input int a, input int b, input int n);
      for (int k = 0; k < n; k++) begin
         qa.push_back(byte'(a));
         qb.push_back(byte'(b));
      end
   endtask

   // Called at a negedge; returns at the negedge after the beat is accepted.
   task automatic drive_beat(input int a, input int b, input bit last);
      int n = 0;
      in_valid = 1'b1;
      in_a     = DW'(a);
      in_b     = DW'(b);
      in_last  = last;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) chk("beat_accept_timeout", 0, 1);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic wait_out(input string name);
      int n = 0;
      while (!out_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk({name, "_out_valid"}, out_valid, 1);
   endtask

   task automatic finish_out(input string name);
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      chk({name, "_valid_drop"}, out_valid, 0);
      chk({name, "_ready_back"}, in_ready, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vec_t vt[6];
      add_beats(16, 16, 1);
      add_beats(-128, 127, 1);
      add_beats(16, 16, 1);
      add_beats(3, -5, 1);
      add_beats(-128, -128, 5);
      add_beats(1, 1, 1);
      add_beats(-128, 127, 5);
      add_beats(127, 127, 1);
      add_beats(3, -3, 8);
      vt[0] = '{0, 1, 256, 1, 1'b0, 1'b0};
      vt[1] = '{1, 3, -16015, 3, 1'b0, 1'b0};
      vt[2] = '{4, 5, 65535, 5, 1'b1, 1'b0};
      vt[3] = '{9, 1, 1, 1, 1'b0, 1'b0};
      vt[4] = '{10, 6, -49407, 6, 1'b1, 1'b0};
      vt[5] = '{16, 8, -72, 8, 1'b0, 1'b0};

      repeat (2) @(negedge clk);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_count", out_count, 0);
      chk("rst_out_sat", out_sat, 0);
      chk("rst_out_trunc", out_trunc, 0);
      rst_n = 1'b1;
      @(negedge clk);

      foreach (vt[i]) begin
         for (int k = 0; k < vt[i].n; k++)
            drive_beat(qa[vt[i].first + k], qb[vt[i].first + k], k == vt[i].n - 1);
         in_valid = 1'b0;
         in_last  = 1'b0;
         chk($sformatf("v%0d_lat_early", i), out_valid, 0);
         chk($sformatf("v%0d_drain_ready", i), in_ready, 0);
         @(negedge clk);
         chk($sformatf("v%0d_latency", i), out_valid, 1);
         chk($sformatf("v%0d_data", i), out_data, vt[i].exp_data);
         chk($sformatf("v%0d_count", i), out_count, vt[i].exp_cnt);
         chk($sformatf("v%0d_sat", i), out_sat, vt[i].exp_sat);
         chk($sformatf("v%0d_trunc", i), out_trunc, vt[i].exp_trunc);
         finish_out($sformatf("v%0d", i));
      end

      // Truncation at MAX_LEN; the ninth beat waits and opens the next vector.
      repeat (ML) drive_beat(1, 1, 1'b0);
      in_valid = 1'b1;
      in_a = 8'sd1;
      in_b = 8'sd1;
      in_last = 1'b1;
      chk("trunc_drain_ready", in_ready, 0);
      @(negedge clk);
      chk("trunc_valid", out_valid, 1);
      chk("trunc_data", out_data, 8);
      chk("trunc_count", out_count, 8);
      chk("trunc_flag", out_trunc, 1);
      chk("trunc_sat", out_sat, 0);
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      chk("trunc_hs_valid", out_valid, 0);
      chk("trunc_hs_ready", in_ready, 1);
      chk("trunc_hs_clear", out_trunc, 0);
      chk("trunc_hs_count", out_count, 0);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      in_last = 1'b0;
      @(negedge clk);
      chk("ninth_valid", out_valid, 1);
      chk("ninth_data", out_data, 1);
      chk("ninth_count", out_count, 1);
      chk("ninth_trunc", out_trunc, 0);
      finish_out("ninth");

      // Backpressure: result held, input pulses ignored.
      drive_beat(2, 2, 1'b1);
      in_valid = 1'b0;
      in_last = 1'b0;
      wait_out("bp");
      chk("bp_data", out_data, 4);
      for (int c = 0; c < 10; c++) begin
         in_valid = c[0];
         in_a = 8'sd99;
         in_b = 8'sd1;
         in_last = 1'b1;
         @(negedge clk);
         chk($sformatf("bp_hold_data_%0d", c), out_data, 4);
         chk($sformatf("bp_hold_ready_%0d", c), in_ready, 0);
         chk($sformatf("bp_hold_valid_%0d", c), out_valid, 1);
      end
      in_valid = 1'b0;
      in_last = 1'b0;
      finish_out("bp");
      drive_beat(1, 1, 1'b1);
      in_valid = 1'b0;
      in_last = 1'b0;
      wait_out("bp_next");
      chk("bp_next_data", out_data, 1);
      chk("bp_next_count", out_count, 1);
      finish_out("bp_next");

      // Asynchronous reset mid-vector discards partial state.
      drive_beat(5, 5, 1'b0);
      drive_beat(5, 5, 1'b0);
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("arst_count", out_count, 0);
      chk("arst_data", out_data, 0);
      chk("arst_ready", in_ready, 1);
      chk("arst_valid", out_valid, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      // out_ready raised early must not produce a phantom handshake.
      out_ready = 1'b1;
      drive_beat(2, 3, 1'b1);
      in_valid = 1'b0;
      in_last = 1'b0;
      chk("post_rst_early", out_valid, 0);
      @(negedge clk);
      chk("post_rst_valid", out_valid, 1);
      chk("post_rst_data", out_data, 6);
      chk("post_rst_count", out_count, 1);
      chk("post_rst_sat", out_sat, 0);
      @(negedge clk);
      chk("post_rst_hs_valid", out_valid, 0);
      chk("post_rst_hs_ready", in_ready, 1);
      out_ready = 1'b0;

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
